char_pixel_gen: RTL and testbench

- Parametrised, pipelined text-mode pixel generator for the VGA path; the successor of the single-glyph font lookup.
- Takes the current raster coordinate from the VGA timing block and fetches the character/attribute word from the text RAM, then the glyph row from the font ROM.
- Applies attribute colouring, per-character blink and a blinking underline cursor.
- Emits a 4-bit colour index per pixel with a fixed 4-cycle latency; palette lookup is done downstream.

---
 rtl/char_pixel_gen_if.sv | 24 ++
 rtl/char_pixel_gen.sv | 143 ++++++++++++++
 tb/tb_char_pixel_gen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/char_pixel_gen_if.sv
// Pixel stream between the VGA timing block and the text-mode pixel generator:
// raster coordinates go in, colour indices come back with the same sideband.
interface char_pixel_gen_if #(
  parameter int H_BITS = 10,
  parameter int V_BITS = 10
);
  logic              in_valid;
  logic              in_de;
  logic [H_BITS-1:0] h;
  logic [V_BITS-1:0] v;
  logic              out_valid;
  logic              out_de;
  logic [3:0]        pix_idx;

  modport master (
    output in_valid, in_de, h, v,
    input  out_valid, out_de, pix_idx
  );

  modport slave (
    input  in_valid, in_de, h, v,
    output out_valid, out_de, pix_idx
  );
endinterface

// File: rtl/char_pixel_gen.sv
// Pipelined text-mode pixel generator: raster coordinate -> text RAM -> font ROM
// -> attribute colouring with blink and underline cursor, fixed 4-cycle latency.
module char_pixel_gen #(
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int H_BITS       = 10,
  parameter int V_BITS       = 10,
  parameter int ADDR_W       = 12,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  char_pixel_gen_if.slave                pix,
  input  logic                           frame_start,
  output logic [ADDR_W-1:0]              txt_addr,
  input  logic [15:0]                    txt_data,
  output logic [8+$clog2(GLYPH_H)-1:0]   font_addr,
  input  logic [GLYPH_W-1:0]             font_data,
  input  logic                           cursor_en,
  input  logic [7:0]                     cursor_col,
  input  logic [7:0]                     cursor_row
);
  localparam int LW = $clog2(GLYPH_W);
  localparam int LH = $clog2(GLYPH_H);

  logic [H_BITS-1:0] col_c;
  logic [V_BITS-1:0] row_c;
  logic              in_range_c;
  logic              cur_c;

  logic          s1_valid, s1_de, s1_rng, s1_cur;
  logic [LW-1:0] s1_xg;
  logic [LH-1:0] s1_yg;

  logic          s2_valid, s2_de, s2_rng, s2_cur;
  logic [LW-1:0] s2_xg;
  logic [7:0]    s2_attr;

  logic          s3_valid, s3_de, s3_rng, s3_cur, s3_glyph;
  logic [7:0]    s3_attr;

  logic [7:0]    frame_cnt;
  logic          blink_phase;
  logic [3:0]    fg, bg, pix_c;

  assign col_c      = pix.h >> LW;
  assign row_c      = pix.v >> LH;
  assign in_range_c = (32'(col_c) < COLS) && (32'(row_c) < ROWS);
  // Cursor position is resolved up front; blink gating happens in the last stage.
  assign cur_c      = cursor_en
                      && (32'(col_c) == 32'(cursor_col))
                      && (32'(row_c) == 32'(cursor_row))
                      && (32'(pix.v[LH-1:0]) >= GLYPH_H - 2);

  // Both memories are read from the registered addresses, so their data is
  // consumed by the stage that follows the address register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_de         <= 1'b0;
      s1_rng        <= 1'b0;
      s1_cur        <= 1'b0;
      s1_xg         <= '0;
      s1_yg         <= '0;
      txt_addr      <= '0;
      s2_valid      <= 1'b0;
      s2_de         <= 1'b0;
      s2_rng        <= 1'b0;
      s2_cur        <= 1'b0;
      s2_xg         <= '0;
      s2_attr       <= '0;
      font_addr     <= '0;
      s3_valid      <= 1'b0;
      s3_de         <= 1'b0;
      s3_rng        <= 1'b0;
      s3_cur        <= 1'b0;
      s3_glyph      <= 1'b0;
      s3_attr       <= '0;
      pix.out_valid <= 1'b0;
      pix.out_de    <= 1'b0;
      pix.pix_idx   <= '0;
    end else begin
      s1_valid      <= pix.in_valid;
      s1_de         <= pix.in_de;
      s1_rng        <= in_range_c;
      s1_cur        <= cur_c;
      s1_xg         <= pix.h[LW-1:0];
      s1_yg         <= pix.v[LH-1:0];
      txt_addr      <= in_range_c ? ADDR_W'(32'(row_c) * COLS + 32'(col_c)) : '0;

      s2_valid      <= s1_valid;
      s2_de         <= s1_de;
      s2_rng        <= s1_rng;
      s2_cur        <= s1_cur;
      s2_xg         <= s1_xg;
      s2_attr       <= txt_data[15:8];
      font_addr     <= {txt_data[7:0], s1_yg};

      s3_valid      <= s2_valid;
      s3_de         <= s2_de;
      s3_rng        <= s2_rng;
      s3_cur        <= s2_cur;
      s3_attr       <= s2_attr;
      s3_glyph      <= font_data[s2_xg];

      pix.out_valid <= s3_valid;
      pix.out_de    <= s3_de;
      pix.pix_idx   <= pix_c;
    end
  end

  assign fg = s3_attr[3:0];
  assign bg = {1'b0, s3_attr[6:4]};

  always_comb begin
    pix_c = bg;
    if (!s3_rng || !s3_de)
      pix_c = '0;
    else if (s3_cur && !blink_phase)
      pix_c = fg;
    else if (s3_attr[7] && blink_phase)
      pix_c = bg;
    else if (s3_glyph)
      pix_c = fg;
  end

  // Blink half-period counted in frames; the phase flips on the wrapping pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_char_pixel_gen.sv
// Directed bench for char_pixel_gen with a small text RAM / font ROM model and
// a 4-deep table of hand-computed expectations checked at fixed latency.
module tb_char_pixel_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [11:0] txt_addr;
  logic [15:0] txt_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        cursor_en = 1'b0;
  logic [7:0]  cursor_col = 8'd5;
  logic [7:0]  cursor_row = 8'd2;

  logic [15:0] ram [0:4095];
  logic [7:0]  rom [0:4095];

  int tests_run = 0;
  int fail_count = 0;

  typedef struct {
    bit known;
    bit valid;
    bit chk_addr;
    int txt;
    int font;
    bit chk_pix;
    int px;
    bit de;
  } exp_t;

  exp_t hist [4];
  int   glyph_exp [8];

  always #5 clk = ~clk;

  char_pixel_gen_if #(.H_BITS(10), .V_BITS(10)) pbus ();

  char_pixel_gen #(
    .GLYPH_W(8), .GLYPH_H(16), .COLS(80), .ROWS(30),
    .H_BITS(10), .V_BITS(10), .ADDR_W(12), .BLINK_FRAMES(2)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix        (pbus),
    .frame_start(frame_start),
    .txt_addr   (txt_addr),
    .txt_data   (txt_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  assign txt_data  = ram[txt_addr];
  assign font_data = rom[font_addr];

  task automatic checkOutput(input string tag, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic clearHist();
    for (int i = 0; i < 4; i++)
      hist[i] = '{known: 1'b1, valid: 1'b0, chk_addr: 1'b0, txt: 0, font: 0,
                  chk_pix: 1'b0, px: 0, de: 1'b0};
  endtask

  // One cycle: check what earlier vectors should show now, then drive a new one.
  task automatic applyStimulus(input bit vld, input bit de, input int hh, input int vv,
                               input bit fs, input bit chk_addr, input int txt,
                               input int font, input bit chk_pix, input int px);
    @(negedge clk);
    if (hist[0].known && hist[0].chk_addr)
      checkOutput("txt_addr", int'(txt_addr), hist[0].txt);
    if (hist[1].known && hist[1].chk_addr)
      checkOutput("font_addr", int'(font_addr), hist[1].font);
    if (hist[3].known) begin
      checkOutput("out_valid", int'(pbus.out_valid), int'(hist[3].valid));
      if (hist[3].valid && hist[3].chk_pix) begin
        checkOutput("pix_idx", int'(pbus.pix_idx), hist[3].px);
        checkOutput("out_de", int'(pbus.out_de), int'(hist[3].de));
      end
    end
    for (int i = 3; i > 0; i--)
      hist[i] = hist[i-1];
    hist[0] = '{known: 1'b1, valid: vld, chk_addr: chk_addr, txt: txt, font: font,
                chk_pix: chk_pix, px: px, de: de};
    pbus.in_valid = vld;
    pbus.in_de    = de;
    pbus.h        = 10'(hh);
    pbus.v        = 10'(vv);
    frame_start   = fs;
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic pulseFrame();
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic flush();
    repeat (4) bubble();
  endtask

  task automatic pixel(input int hh, input int vv, input int txt, input int font, input int px);
    applyStimulus(1'b1, 1'b1, hh, vv, 1'b0, 1'b1, txt, font, 1'b1, px);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n         = 1'b0;
    pbus.in_valid = 1'b0;
    pbus.in_de    = 1'b0;
    pbus.h        = '0;
    pbus.v        = '0;
    frame_start   = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", int'(pbus.out_valid), 0);
    checkOutput("rst_out_de", int'(pbus.out_de), 0);
    checkOutput("rst_pix_idx", int'(pbus.pix_idx), 0);
    checkOutput("rst_txt_addr", int'(txt_addr), 0);
    checkOutput("rst_font_addr", int'(font_addr), 0);
    rst_n = 1'b1;
    clearHist();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 16'h0000;
      rom[i] = 8'h00;
    end
    ram[0]    = {8'h1E, 8'h41};
    ram[1]    = {8'h9F, 8'h42};
    ram[165]  = {8'h2C, 8'h43};
    ram[2399] = {8'h4A, 8'h44};
    rom[{8'h41, 4'd3}]  = 8'b0001_1000;
    rom[{8'h42, 4'd0}]  = 8'hFF;
    rom[{8'h43, 4'd13}] = 8'h01;
    rom[{8'h44, 4'd15}] = 8'h80;
    glyph_exp = '{1, 1, 1, 14, 14, 1, 1, 1};

    pbus.in_valid = 1'b0;
    pbus.in_de    = 1'b0;
    pbus.h        = '0;
    pbus.v        = '0;
    resetDut();

    // Glyph row 3 of 'A' with attr 1E
    for (int x = 0; x < 8; x++)
      pixel(x, 3, 0, 12'h413, glyph_exp[x]);
    flush();

    // Alternating bubbles
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) pixel(i / 2, 3, 0, 12'h413, glyph_exp[i / 2]);
      else bubble();
    end
    flush();

    // Out-of-range, display-enable low, last column/row
    pixel(640, 0, 0, 12'h410, 0);
    pixel(0, 480, 0, 12'h410, 0);
    applyStimulus(1'b1, 1'b0, 3, 3, 1'b0, 1'b1, 0, 12'h413, 1'b1, 0);
    pixel(639, 479, 12'h95F, 12'h44F, 10);
    pixel(632, 479, 12'h95F, 12'h44F, 4);
    flush();

    // Cursor at col 5 row 2
    cursor_en = 1'b1;
    pixel(41, 46, 165, 12'h43E, 12);
    pixel(40, 47, 165, 12'h43F, 12);
    pixel(40, 45, 165, 12'h43D, 12);
    pixel(41, 45, 165, 12'h43D, 2);
    flush();
    cursor_en = 1'b0;
    pixel(41, 46, 165, 12'h43E, 2);
    flush();
    cursor_en = 1'b1;

    // Blink with a 2-frame half-period
    pixel(8, 0, 1, 12'h420, 15);
    flush();
    pulseFrame();
    pixel(8, 0, 1, 12'h420, 15);
    flush();
    pulseFrame();
    pixel(8, 0, 1, 12'h420, 1);
    pixel(3, 3, 0, 12'h413, 14);
    pixel(41, 46, 165, 12'h43E, 2);
    pixel(40, 45, 165, 12'h43D, 12);
    flush();
    pulseFrame();
    pixel(8, 0, 1, 12'h420, 1);
    flush();
    applyStimulus(1'b1, 1'b1, 8, 0, 1'b1, 1'b1, 1, 12'h420, 1'b1, 15);
    flush();

    // Leave counter at 1 with phase 1, then reset with pixels in flight
    pulseFrame();
    pulseFrame();
    pulseFrame();
    pixel(8, 0, 1, 12'h420, 1);
    flush();
    for (int x = 0; x < 4; x++)
      applyStimulus(1'b1, 1'b1, x, 3, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    resetDut();
    flush();
    pixel(8, 0, 1, 12'h420, 15);
    flush();
    pulseFrame();
    pixel(8, 0, 1, 12'h420, 15);
    flush();
    pulseFrame();
    pixel(8, 0, 1, 12'h420, 1);
    for (int x = 0; x < 8; x++)
      pixel(x, 3, 0, 12'h413, glyph_exp[x]);
    flush();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end
endmodule
